// File: rtl/openmips_ifetch.sv
// openmips_ifetch: instruction-fetch initiator for the openmips core.
// It holds the PC, drives the instruction ROM read port and captures
// each returned word into an IF/ID register with a valid flag.
// It also handles decode stall, branch/jump redirect with flush, halt,
// and out-of-range fetch faults.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN.
//   When defined, a misaligned redirect target faults and halts.
//   When undefined, the low two bits of the target are cleared.
`ifndef PC_BASE_ADDR
`define PC_BASE_ADDR 32'h8000_0000
`endif

module openmips_ifetch #(
  parameter logic [31:0] PC_BASE   = `PC_BASE_ADDR,
  parameter int unsigned ROM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        openmips_instrom_ren,
  output logic [31:0] openmips_instrom_addr,
  input  logic [31:0] instrom_openmips_data,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_inst_o,
  output logic [31:0] if_id_pc_o,
  output logic        fetch_fault_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

  // An address below PC_BASE wraps to a large offset, so a single unsigned
  // compare covers both ends of the legal window.
  function automatic logic in_range(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - PC_BASE;
    return (off < ROM_BYTES);
  endfunction

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        fault_q, fault_d;

  // Next-state, PC and IF/ID update with the per-cycle RUN priority:
  // halt, redirect, stall, range fault, normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ifpc_d  = ifpc_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_en_i) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (halt_i) begin
          state_d = S_HALT;
          valid_d = 1'b0;
        end else if (redirect_i) begin
          // A redirect flushes IF/ID and wins over a stall in the same cycle.
          valid_d = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (redirect_pc_i[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d = redirect_pc_i;
          end
`else
          pc_d = {redirect_pc_i[31:2], 2'b00};
`endif
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (!in_range(pc_q)) begin
          state_d = S_HALT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else begin
          inst_d  = instrom_openmips_data;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers. The reset is synchronous and active-low,
  // and it overrides every register together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= PC_BASE;
      valid_q <= 1'b0;
      inst_q  <= 32'h0000_0000;
      ifpc_q  <= 32'h0000_0000;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
      fault_q <= fault_d;
    end
  end

  // The ROM read port is combinational. The ROM is read only while running,
  // unstalled and in range, and the address always tracks the PC.
  always_comb begin
    openmips_instrom_ren  = (state_q == S_RUN) && !stall_i && in_range(pc_q);
    openmips_instrom_addr = pc_q;
  end

  assign if_id_valid_o = valid_q;
  assign if_id_inst_o  = inst_q;
  assign if_id_pc_o    = ifpc_q;
  assign fetch_fault_o = fault_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_openmips_ifetch.sv
// Directed self-checking bench for openmips_ifetch.
// ROM word i holds 32'hC0DE_0000 | i.
module tb_openmips_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        ren;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] ifpc;
  logic        fault;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ROM model: word index comes from the byte offset; garbage outside the ROM.
  always_comb begin
    if ((addr - 32'h8000_0000) < 32'd128) rdata = 32'hC0DE_0000 | {27'd0, addr[6:2]};
    else rdata = 32'hDEAD_BEEF;
  end

  openmips_ifetch dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
    .openmips_instrom_ren(ren), .openmips_instrom_addr(addr),
    .instrom_openmips_data(rdata), .if_id_valid_o(valid), .if_id_inst_o(inst),
    .if_id_pc_o(ifpc), .fetch_fault_o(fault), .state_o(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_en_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; halt_i = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state); end
    checks++; if ({valid, fault, ren} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {valid, fault, ren}); end
    checks++; if (inst !== 32'h0 || ifpc !== 32'h0) begin errors++; $display("FAIL reset_ifid got %h/%h exp 0/0", inst, ifpc); end
    checks++; if (addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr got %h exp 80000000", addr); end
  endtask

  task automatic test_fetch();
    fetch_en_i = 1'b1;
    tick();
    checks++; if (state !== 2'b01 || valid !== 1'b0 || ren !== 1'b1) begin errors++; $display("FAIL run_entry got st=%b v=%b ren=%b exp 01/0/1", state, valid, ren); end
    tick();
    checks++; if (valid !== 1'b1 || inst !== 32'hC0DE_0000 || ifpc !== 32'h8000_0000) begin errors++; $display("FAIL fetch_A got v=%b %h@%h exp 1 c0de0000@80000000", valid, inst, ifpc); end
    tick();
    checks++; if (valid !== 1'b1 || inst !== 32'hC0DE_0001 || ifpc !== 32'h8000_0004) begin errors++; $display("FAIL fetch_B got v=%b %h@%h exp 1 c0de0001@80000004", valid, inst, ifpc); end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    #1;
    checks++; if (ren !== 1'b0) begin errors++; $display("FAIL stall_ren got %b exp 0", ren); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (valid !== 1'b1 || inst !== 32'hC0DE_0001 || ifpc !== 32'h8000_0004 || ren !== 1'b0 || addr !== 32'h8000_0008) begin
      errors++; $display("FAIL stall_hold got v=%b %h@%h ren=%b addr=%h exp 1 c0de0001@80000004 0 80000008", valid, inst, ifpc, ren, addr); end
    stall_i = 1'b0;
    tick();
    checks++; if (valid !== 1'b1 || inst !== 32'hC0DE_0002 || ifpc !== 32'h8000_0008) begin errors++; $display("FAIL fetch_C got %h@%h exp c0de0002@80000008", inst, ifpc); end
    tick();
    checks++; if (valid !== 1'b1 || inst !== 32'hC0DE_0003 || ifpc !== 32'h8000_000C) begin errors++; $display("FAIL fetch_D got %h@%h exp c0de0003@8000000c", inst, ifpc); end
  endtask

  task automatic test_redirect();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0010; stall_i = 1'b1;
    tick();
    redirect_i = 1'b0; stall_i = 1'b0;
    checks++; if (valid !== 1'b0 || addr !== 32'h8000_0010) begin errors++; $display("FAIL redirect_flush got v=%b addr=%h exp 0 80000010", valid, addr); end
    tick();
    checks++; if (valid !== 1'b1 || inst !== 32'hC0DE_0004 || ifpc !== 32'h8000_0010 || addr !== 32'h8000_0014) begin
      errors++; $display("FAIL redirect_target got %h@%h addr=%h exp c0de0004@80000010 80000014", inst, ifpc, addr); end
  endtask

  task automatic test_range_end();
    for (int i = 5; i < 32; i++) tick();
    checks++; if (valid !== 1'b1 || inst !== 32'hC0DE_001F || ifpc !== 32'h8000_007C) begin errors++; $display("FAIL last_word got %h@%h exp c0de001f@8000007c", inst, ifpc); end
    checks++; if (addr !== 32'h8000_0080 || ren !== 1'b0 || state !== 2'b01) begin errors++; $display("FAIL edge_ren got addr=%h ren=%b st=%b exp 80000080 0 01", addr, ren, state); end
    tick();
    checks++; if (state !== 2'b10 || fault !== 1'b1 || valid !== 1'b0 || ren !== 1'b0) begin errors++; $display("FAIL range_fault got st=%b f=%b v=%b ren=%b exp 10 1 0 0", state, fault, valid, ren); end
    tick();
    checks++; if (state !== 2'b10 || fault !== 1'b1 || addr !== 32'h8000_0080) begin errors++; $display("FAIL halt_sticky got st=%b f=%b addr=%h exp 10 1 80000080", state, fault, addr); end
  endtask

  task automatic test_misalign();
    do_reset();
    checks++; if (fault !== 1'b0 || state !== 2'b00) begin errors++; $display("FAIL fault_clear got f=%b st=%b exp 0 00", fault, state); end
    fetch_en_i = 1'b1;
    tick(); tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0006;
    tick();
    redirect_i = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    checks++; if (state !== 2'b10 || fault !== 1'b1 || addr !== 32'h8000_0004 || valid !== 1'b0) begin
      errors++; $display("FAIL misalign_trap got st=%b f=%b addr=%h v=%b exp 10 1 80000004 0", state, fault, addr, valid); end
`else
    checks++; if (state !== 2'b01 || fault !== 1'b0 || addr !== 32'h8000_0004 || valid !== 1'b0) begin
      errors++; $display("FAIL misalign_force got st=%b f=%b addr=%h v=%b exp 01 0 80000004 0", state, fault, addr, valid); end
    tick();
    checks++; if (valid !== 1'b1 || inst !== 32'hC0DE_0001 || ifpc !== 32'h8000_0004) begin errors++; $display("FAIL misalign_fetch got %h@%h exp c0de0001@80000004", inst, ifpc); end
`endif
  endtask

  task automatic test_below_base();
    do_reset();
    fetch_en_i = 1'b1;
    tick(); tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h7FFF_FFFC;
    tick();
    redirect_i = 1'b0;
    checks++; if (ren !== 1'b0 || state !== 2'b01) begin errors++; $display("FAIL below_ren got ren=%b st=%b exp 0 01", ren, state); end
    tick();
    checks++; if (state !== 2'b10 || fault !== 1'b1) begin errors++; $display("FAIL below_fault got st=%b f=%b exp 10 1", state, fault); end
  endtask

  task automatic test_halt_reset();
    do_reset();
    fetch_en_i = 1'b1;
    tick(); tick();
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    checks++; if (state !== 2'b10 || valid !== 1'b0 || fault !== 1'b0 || addr !== 32'h8000_0004) begin
      errors++; $display("FAIL halt got st=%b v=%b f=%b addr=%h exp 10 0 0 80000004", state, valid, fault, addr); end
    tick(); tick();
    checks++; if (state !== 2'b10 || ren !== 1'b0 || addr !== 32'h8000_0004) begin errors++; $display("FAIL halt_frozen got st=%b ren=%b addr=%h exp 10 0 80000004", state, ren, addr); end
    do_reset();
    checks++; if (state !== 2'b00 || addr !== 32'h8000_0000 || valid !== 1'b0 || inst !== 32'h0 || ifpc !== 32'h0 || fault !== 1'b0 || ren !== 1'b0) begin
      errors++; $display("FAIL halt_reset got st=%b addr=%h v=%b %h@%h f=%b ren=%b exp 00 80000000 0 0@0 0 0", state, addr, valid, inst, ifpc, fault, ren); end
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL idle_hold got st=%b exp 00", state); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_range_end();
    test_misalign();
    test_below_base();
    test_halt_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
